// File: rtl/bypass_rf_wb_arbiter_pkg.sv
// Shared types and constants for the bypass register file write-back arbiter.
// Holds the request payload, counter width and pointer width derivation.
package bypass_rf_wb_arbiter_pkg;

   localparam int CNT_W      = 16;
   localparam int WB_NAME_MX = 8;
   localparam int WB_DATA_MX = 64;

   // Widest payload any instance may carry; narrower instances zero-extend.
   typedef struct packed {
      logic [WB_NAME_MX-1:0] name;
      logic [WB_DATA_MX-1:0] data;
   } wb_req_t;

   function automatic int ptr_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/bypass_rf_wb_arbiter_rr_pick2.sv
// Two-winner rotating priority picker.
// Index i_ptr has top priority; the first two set bits win.
module rr_pick2 #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt_a,
   output logic [NREQ-1:0] o_gnt_b,
   output logic            o_va,
   output logic            o_vb
);

   logic [PW-1:0] w_idx;

   always_comb begin
      o_gnt_a = '0;
      o_gnt_b = '0;
      o_va    = 1'b0;
      o_vb    = 1'b0;
      w_idx   = i_ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (i_req[w_idx]) begin
            if (!o_va) begin
               o_gnt_a[w_idx] = 1'b1;
               o_va           = 1'b1;
            end else if (!o_vb) begin
               o_gnt_b[w_idx] = 1'b1;
               o_vb           = 1'b1;
            end
         end
         // Explicit wrap so non-power-of-two NREQ never walks off the end.
         if (w_idx == PW'(NREQ - 1)) w_idx = '0;
         else                        w_idx = w_idx + PW'(1);
      end
   end

endmodule

// File: rtl/bypass_rf_wb_arbiter.sv
// Write-back arbiter: shares the two register file write ports among
// NREQ requesters with rotating priority and a one-stage output register.
module bypass_rf_wb_arbiter
   import bypass_rf_wb_arbiter_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int name_width = 1,
   parameter int data_width = 1,
   parameter int ptr_width  = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NREQ-1:0]            REQ_VALID,
   input  logic [NREQ*name_width-1:0] REQ_NAME,
   input  logic [NREQ*data_width-1:0] REQ_DATA,
   output logic [NREQ-1:0]            REQ_READY,
   output logic                       WE_1,
   output logic                       WE_2,
   output logic [name_width-1:0]      NAME_IN_1,
   output logic [name_width-1:0]      NAME_IN_2,
   output logic [data_width-1:0]      D_IN_1,
   output logic [data_width-1:0]      D_IN_2,
   output logic [CNT_W-1:0]           CONFLICT_CNT
);

   logic [ptr_width-1:0] r_ptr;
   logic                 r_we1;
   logic                 r_we2;
   wb_req_t              r_p1;
   wb_req_t              r_p2;
   logic [CNT_W-1:0]     r_cnt;

   logic [NREQ-1:0]      w_gnt_a;
   logic [NREQ-1:0]      w_gnt_b;
   logic                 w_va;
   logic                 w_vb;
   logic                 w_gb;
   logic                 w_same;
   logic                 w_conf;
   logic [ptr_width-1:0] w_idx_a;
   logic [ptr_width-1:0] w_idx_b;
   logic [ptr_width-1:0] w_last;
   logic [ptr_width-1:0] w_ptr_nxt;
   wb_req_t              w_pay_a;
   wb_req_t              w_pay_b;
   logic                 w_unused;

   rr_pick2 #(
      .NREQ (NREQ),
      .PW   (ptr_width)
   ) u_pick (
      .i_req   (REQ_VALID),
      .i_ptr   (r_ptr),
      .o_gnt_a (w_gnt_a),
      .o_gnt_b (w_gnt_b),
      .o_va    (w_va),
      .o_vb    (w_vb)
   );

   always_comb begin
      w_idx_a = '0;
      w_idx_b = '0;
      w_pay_a = '0;
      w_pay_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_a[i]) begin
            w_idx_a = ptr_width'(i);
            w_pay_a.name[name_width-1:0] =
               REQ_NAME[i*name_width +: name_width];
            w_pay_a.data[data_width-1:0] =
               REQ_DATA[i*data_width +: data_width];
         end
         if (w_gnt_b[i]) begin
            w_idx_b = ptr_width'(i);
            w_pay_b.name[name_width-1:0] =
               REQ_NAME[i*name_width +: name_width];
            w_pay_b.data[data_width-1:0] =
               REQ_DATA[i*data_width +: data_width];
         end
      end
   end

   // Two writes to one name in a cycle would race; B waits instead.
   assign w_same = w_vb && (w_pay_a.name == w_pay_b.name);
   assign w_gb   = w_vb && !w_same;

   assign w_last    = w_gb ? w_idx_b : w_idx_a;
   assign w_ptr_nxt = (w_last == ptr_width'(NREQ - 1)) ?
                      '0 : w_last + ptr_width'(1);

   assign w_conf = ($countones(REQ_VALID) > 2);

   always_comb begin
      REQ_READY = '0;
      if (!RST) begin
         if (w_va) REQ_READY = REQ_READY | w_gnt_a;
         if (w_gb) REQ_READY = REQ_READY | w_gnt_b;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ptr <= '0;
         r_we1 <= 1'b0;
         r_we2 <= 1'b0;
         r_p1  <= '0;
         r_p2  <= '0;
         r_cnt <= '0;
      end else begin
         r_we1 <= w_va;
         r_we2 <= w_gb;
         if (w_va) begin
            r_p1  <= w_pay_a;
            r_ptr <= w_ptr_nxt;
         end
         if (w_gb) r_p2 <= w_pay_b;
         if (w_conf && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign WE_1         = r_we1;
   assign WE_2         = r_we2;
   assign NAME_IN_1    = r_p1.name[name_width-1:0];
   assign NAME_IN_2    = r_p2.name[name_width-1:0];
   assign D_IN_1       = r_p1.data[data_width-1:0];
   assign D_IN_2       = r_p2.data[data_width-1:0];
   assign CONFLICT_CNT = r_cnt;

   // Padding bits above the instance widths are always zero.
   assign w_unused = ^{r_p1, r_p2};

endmodule

// File: tb/tb_bypass_rf_wb_arbiter.sv
// Self-checking bench for bypass_rf_wb_arbiter: directed steps plus random
// traffic against a list-based reference model of the arbitration rules.
module tb_bypass_rf_wb_arbiter;
   import bypass_rf_wb_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int NW = 4;
   localparam int DW = 8;
   localparam int PW = ptr_w(N);

   logic            CLK = 1'b0;
   logic            RST;
   logic [N-1:0]    REQ_VALID;
   logic [N*NW-1:0] REQ_NAME;
   logic [N*DW-1:0] REQ_DATA;
   logic [N-1:0]    REQ_READY;
   logic            WE_1, WE_2;
   logic [NW-1:0]   NAME_IN_1, NAME_IN_2;
   logic [DW-1:0]   D_IN_1, D_IN_2;
   logic [15:0]     CONFLICT_CNT;

   logic [NW-1:0] nm [N];
   logic [DW-1:0] dt [N];
   logic [N-1:0]  vld;
   logic [N-1:0]  last_rdy;

   int total = 0;
   int bad   = 0;

   int            m_ptr = 0;
   logic          m_we1 = 0, m_we2 = 0;
   logic [NW-1:0] m_n1 = 0, m_n2 = 0;
   logic [DW-1:0] m_d1 = 0, m_d2 = 0;
   int            m_cnt = 0;

   bypass_rf_wb_arbiter #(
      .NREQ(N), .name_width(NW), .data_width(DW), .ptr_width(PW)
   ) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_NAME(REQ_NAME), .REQ_DATA(REQ_DATA),
      .REQ_READY(REQ_READY),
      .WE_1(WE_1), .WE_2(WE_2),
      .NAME_IN_1(NAME_IN_1), .NAME_IN_2(NAME_IN_2),
      .D_IN_1(D_IN_1), .D_IN_2(D_IN_2),
      .CONFLICT_CNT(CONFLICT_CNT)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      REQ_VALID = vld;
      REQ_NAME  = '0;
      REQ_DATA  = '0;
      for (int i = 0; i < N; i++) begin
         REQ_NAME[i*NW +: NW] = nm[i];
         REQ_DATA[i*DW +: DW] = dt[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Walk requesters in priority order from the pointer; take two.
   task automatic model_pick(output int a, output int b);
      a = -1;
      b = -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (vld[i]) begin
            if (a < 0)      a = i;
            else if (b < 0) b = i;
         end
      end
      if (b >= 0 && nm[b] == nm[a]) b = -1;
   endtask

   task automatic cycle(input bit en);
      int a, b, nv;
      logic [N-1:0] er;
      #1;
      model_pick(a, b);
      er = '0;
      if (!RST) begin
         if (a >= 0) er[a] = 1'b1;
         if (b >= 0) er[b] = 1'b1;
      end
      if (en) chk("ready", 32'(REQ_READY), 32'(er));
      last_rdy = er;
      nv = $countones(vld);
      @(posedge CLK);
      if (RST) begin
         m_we1 = 0; m_we2 = 0;
         m_n1 = 0; m_n2 = 0; m_d1 = 0; m_d2 = 0;
         m_ptr = 0; m_cnt = 0;
      end else begin
         m_we1 = (a >= 0);
         m_we2 = (b >= 0);
         if (a >= 0) begin m_n1 = nm[a]; m_d1 = dt[a]; end
         if (b >= 0) begin m_n2 = nm[b]; m_d2 = dt[b]; end
         if (a >= 0) m_ptr = (((b >= 0) ? b : a) + 1) % N;
         if (nv > 2 && m_cnt < 65535) m_cnt++;
      end
      @(negedge CLK);
      if (en) begin
         chk("we1", 32'(WE_1), 32'(m_we1));
         chk("we2", 32'(WE_2), 32'(m_we2));
         chk("name1", 32'(NAME_IN_1), 32'(m_n1));
         chk("name2", 32'(NAME_IN_2), 32'(m_n2));
         chk("d1", 32'(D_IN_1), 32'(m_d1));
         chk("d2", 32'(D_IN_2), 32'(m_d2));
         chk("cnt", 32'(CONFLICT_CNT), 32'(m_cnt));
      end
   endtask

   task automatic req(input int i, input bit v, input int n, input int d);
      vld[i] = v;
      nm[i]  = NW'(n);
      dt[i]  = DW'(d);
   endtask

   initial begin
      RST = 1'b1;
      vld = '0;
      for (int i = 0; i < N; i++) begin nm[i] = '0; dt[i] = '0; end

      // reset and idle
      cycle(1);
      cycle(1);
      RST = 1'b0;
      cycle(1);
      chk("idle_cnt", 32'(CONFLICT_CNT), 32'h0);

      // two distinct requests from ptr 0
      req(0, 1, 2, 'hAA);
      req(2, 1, 3, 'hBB);
      #1 chk("two_rdy", 32'(REQ_READY), 32'b0101);
      cycle(1);
      chk("two_d1", 32'(D_IN_1), 32'hAA);
      chk("two_d2", 32'(D_IN_2), 32'hBB);

      // pointer wrap from 3
      vld = '0;
      req(3, 1, 1, 'h33);
      req(0, 1, 4, 'h44);
      cycle(1);
      chk("wrap_n1", 32'(NAME_IN_1), 32'h1);
      chk("wrap_n2", 32'(NAME_IN_2), 32'h4);

      // same-name collision from ptr 1
      vld = '0;
      req(1, 1, 5, 'h11);
      req(2, 1, 5, 'h22);
      #1 chk("same_rdy", 32'(REQ_READY), 32'b0010);
      cycle(1);
      chk("same_we2", 32'(WE_2), 32'h0);
      vld[1] = 1'b0;
      cycle(1);
      chk("same_d1", 32'(D_IN_1), 32'h22);

      // lone requester, then full round robin
      vld = '0;
      req(3, 1, 9, 'h99);
      cycle(1);
      for (int i = 0; i < N; i++) req(i, 1, i + 8, i * 16 + 1);
      for (int c = 0; c < 6; c++) cycle(1);
      chk("rr_cnt", 32'(CONFLICT_CNT), 32'd6);

      // random traffic honouring hold-until-granted
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!vld[i] || last_rdy[i])
               req(i, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
         cycle(1);
      end

      // saturation
      for (int i = 0; i < N; i++) req(i, 1, i, i);
      for (int c = 0; c < 65540; c++) cycle(0);
      cycle(1);
      chk("sat", 32'(CONFLICT_CNT), 32'hFFFF);
      cycle(1);
      chk("sat_hold", 32'(CONFLICT_CNT), 32'hFFFF);

      // reset during a grant cycle
      RST = 1'b1;
      cycle(1);
      chk("rst_we1", 32'(WE_1), 32'h0);
      chk("rst_cnt", 32'(CONFLICT_CNT), 32'h0);
      RST = 1'b0;
      cycle(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
